// File: rtl/multi_port_dist_ram_pkg.sv
// Shared types and helpers for the multi-port distributed RAM:
// the clear/run state encoding and the live-value-table select width.
package multi_port_dist_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } ram_state_e;

  function automatic int ram_sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lvt_ram_bank.sv
// One DEPTH x WIDTH bank with a single synchronous write port and a
// single asynchronous read port; contents are not reset.
module lvt_ram_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Storage write on the rising edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/multi_port_dist_ram.sv
// NUM_WRITE x NUM_READ multi-port RAM built from 1W1R banks steered by a
// live-value table, with optional write-to-read bypass and a post-reset zero sweep.
module multi_port_dist_ram
  import multi_port_dist_ram_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int DEPTH          = 32,
  parameter int NUM_READ       = 2,
  parameter int NUM_WRITE      = 2,
  parameter int BYPASS         = 0,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH    = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            resetn,
  output logic                            ready,
  input  logic [NUM_WRITE-1:0]            we,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*WIDTH-1:0]      wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0]  raddr,
  output logic [NUM_READ*WIDTH-1:0]       rdata
);

  localparam int SEL_WIDTH = ram_sel_width(NUM_WRITE);

  ram_state_e            state_r;
  logic [ADDR_WIDTH-1:0] cnt_r;
  logic                  ready_r;
  logic [SEL_WIDTH-1:0]  lvt_r [DEPTH];
  logic                  clear_s;

  logic [NUM_WRITE-1:0]  bank_we_s;
  logic [ADDR_WIDTH-1:0] bank_waddr_s [NUM_WRITE];
  logic [WIDTH-1:0]      bank_wdata_s [NUM_WRITE];
  logic [WIDTH-1:0]      bank_rdata_s [NUM_WRITE][NUM_READ];
  logic [SEL_WIDTH-1:0]  rsel_s  [NUM_READ];
  logic [WIDTH-1:0]      rword_s [NUM_READ];

  assign clear_s = (state_r == ST_CLEAR);
  assign ready   = ready_r;

  // Bank write steering: the sweep takes over every bank while clearing.
  always_comb begin
    for (int w = 0; w < NUM_WRITE; w++) begin
      bank_we_s[w]    = clear_s | we[w];
      bank_waddr_s[w] = clear_s ? cnt_r : waddr[w*ADDR_WIDTH +: ADDR_WIDTH];
      bank_wdata_s[w] = clear_s ? {WIDTH{1'b0}} : wdata[w*WIDTH +: WIDTH];
    end
  end

  for (genvar gw = 0; gw < NUM_WRITE; gw++) begin : g_wr
    for (genvar gr = 0; gr < NUM_READ; gr++) begin : g_rd
      lvt_ram_bank #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
      ) u_bank (
        .clk   (clk),
        .we    (bank_we_s[gw]),
        .waddr (bank_waddr_s[gw]),
        .wdata (bank_wdata_s[gw]),
        .raddr (raddr[gr*ADDR_WIDTH +: ADDR_WIDTH]),
        .rdata (bank_rdata_s[gw][gr])
      );
    end
  end

  // Clear/run sequencing; ready rises on the edge that clears the last entry.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
      cnt_r   <= {ADDR_WIDTH{1'b0}};
      ready_r <= (CLEAR_ON_RESET == 0);
    end else begin
      case (state_r)
        ST_CLEAR: begin
          cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
          if (cnt_r == ADDR_WIDTH'(DEPTH - 1)) begin
            state_r <= ST_RUN;
            ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_CLEAR;
          cnt_r   <= {ADDR_WIDTH{1'b0}};
          ready_r <= 1'b0;
        end
      endcase
    end
  end

  // Live-value table: later loop iterations override, so the highest port wins.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        lvt_r[i] <= {SEL_WIDTH{1'b0}};
      end
    end else if (clear_s) begin
      lvt_r[cnt_r] <= {SEL_WIDTH{1'b0}};
    end else begin
      for (int w = 0; w < NUM_WRITE; w++) begin
        if (we[w]) begin
          lvt_r[waddr[w*ADDR_WIDTH +: ADDR_WIDTH]] <= SEL_WIDTH'(w);
        end
      end
    end
  end

  // Read path: LVT-selected bank, optional same-cycle bypass, zero while clearing.
  always_comb begin
    rdata = {(NUM_READ*WIDTH){1'b0}};
    for (int r = 0; r < NUM_READ; r++) begin
      rsel_s[r]  = lvt_r[raddr[r*ADDR_WIDTH +: ADDR_WIDTH]];
      rword_s[r] = {WIDTH{1'b0}};
      for (int w = 0; w < NUM_WRITE; w++) begin
        rword_s[r] = (rsel_s[r] == SEL_WIDTH'(w)) ? bank_rdata_s[w][r] : rword_s[r];
      end
      for (int w = 0; w < NUM_WRITE; w++) begin
        rword_s[r] = ((BYPASS != 0) && we[w] &&
                      (waddr[w*ADDR_WIDTH +: ADDR_WIDTH] == raddr[r*ADDR_WIDTH +: ADDR_WIDTH]))
                     ? wdata[w*WIDTH +: WIDTH] : rword_s[r];
      end
      rdata[r*WIDTH +: WIDTH] = clear_s ? {WIDTH{1'b0}} : rword_s[r];
    end
  end

endmodule

// File: tb/tb_multi_port_dist_ram.sv
// Drives a non-bypass and a bypass instance with shared stimulus and checks
// both against an array-based reference model of the RAM.
module tb_multi_port_dist_ram;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int ND = 32;

  logic           clk = 1'b0;
  logic           resetn;
  logic [1:0]     we;
  logic [2*AW-1:0] waddr;
  logic [2*DW-1:0] wdata;
  logic [2*AW-1:0] raddr;
  logic [2*DW-1:0] rdata_nb, rdata_b;
  logic           ready_nb, ready_b;

  logic [DW-1:0]  mem [ND];
  int             sweep_left;
  int             errors = 0;
  int             checks = 0;

  always #5 clk = ~clk;

  multi_port_dist_ram #(.BYPASS(0)) dut_nb (
    .clk(clk), .resetn(resetn), .ready(ready_nb), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_nb)
  );

  multi_port_dist_ram #(.BYPASS(1)) dut_b (
    .clk(clk), .resetn(resetn), .ready(ready_b), .we(we),
    .waddr(waddr), .wdata(wdata), .raddr(raddr), .rdata(rdata_b)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_read(input int r, input bit byp);
    logic [AW-1:0] a;
    logic [DW-1:0] v;
    if (sweep_left != 0) return '0;
    a = raddr[r*AW +: AW];
    v = mem[a];
    if (byp) begin
      for (int w = 0; w < 2; w++)
        if (we[w] && waddr[w*AW +: AW] == a) v = wdata[w*DW +: DW];
    end
    return v;
  endfunction

  task automatic idle();
    we = 2'b00;
  endtask

  task automatic wr(input int p, input int a, input logic [DW-1:0] d);
    we[p] = 1'b1;
    waddr[p*AW +: AW] = AW'(a);
    wdata[p*DW +: DW] = d;
  endtask

  task automatic rd(input int p, input int a);
    raddr[p*AW +: AW] = AW'(a);
  endtask

  task automatic randomize_inputs();
    we    = 2'($urandom_range(0, 3));
    waddr = {AW'($urandom), AW'($urandom)};
    wdata = {$urandom, $urandom};
    raddr = {AW'($urandom), AW'($urandom)};
  endtask

  // Check outputs mid-cycle, then advance the model across the rising edge.
  task automatic cycle();
    @(negedge clk);
    chk("ready_nb", {31'd0, ready_nb}, {31'd0, sweep_left == 0});
    chk("ready_b",  {31'd0, ready_b},  {31'd0, sweep_left == 0});
    for (int r = 0; r < 2; r++) begin
      chk($sformatf("rdata_nb[%0d]@%0d", r, raddr[r*AW +: AW]), rdata_nb[r*DW +: DW], model_read(r, 1'b0));
      chk($sformatf("rdata_b[%0d]@%0d",  r, raddr[r*AW +: AW]), rdata_b[r*DW +: DW],  model_read(r, 1'b1));
    end
    @(posedge clk);
    if (sweep_left == 0) begin
      for (int w = 0; w < 2; w++)
        if (we[w]) mem[waddr[w*AW +: AW]] = wdata[w*DW +: DW];
    end else begin
      sweep_left--;
      if (sweep_left == 0)
        for (int i = 0; i < ND; i++) mem[i] = '0;
    end
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("ready_in_reset_nb", {31'd0, ready_nb}, 32'd0);
    chk("ready_in_reset_b",  {31'd0, ready_b},  32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    sweep_left = ND;
  endtask

  task automatic read_all();
    idle();
    for (int i = 0; i < ND / 2; i++) begin
      rd(0, 2 * i);
      rd(1, 2 * i + 1);
      cycle();
    end
  endtask

  initial begin
    resetn = 1'b1;
    we = '0; waddr = '0; wdata = '0; raddr = '0;
    for (int i = 0; i < ND; i++) mem[i] = 'x;
    sweep_left = ND;
    @(posedge clk);
    #1;

    // Power-on sweep with random traffic and a blocked write to entry 0.
    do_reset();
    for (int i = 0; i < ND; i++) begin
      randomize_inputs();
      if (i == 2) begin
        idle();
        wr(0, 0, 32'h0000_FFFF);
      end
      cycle();
    end
    read_all();

    // Two-port write then read back.
    idle();
    wr(0, 5, 32'hDEAD_BEEF);
    wr(1, 9, 32'h1234_5678);
    rd(0, 5); rd(1, 9);
    cycle();
    idle();
    cycle();

    // Same-address conflict: port 1 must win, then a later port 0 write.
    wr(0, 7, 32'h0000_1111);
    wr(1, 7, 32'h0000_2222);
    rd(0, 7); rd(1, 7);
    cycle();
    idle();
    cycle();
    wr(0, 7, 32'h0000_3333);
    cycle();
    idle();
    cycle();

    // Bypass observation on read port 0 at address 3.
    wr(1, 3, 32'h0000_CAFE);
    rd(0, 3); rd(1, 4);
    cycle();
    idle();
    cycle();

    // Random traffic, including conflicts and bypass hits.
    for (int i = 0; i < 200; i++) begin
      randomize_inputs();
      if (i % 7 == 0) waddr[2*AW-1:AW] = waddr[AW-1:0];
      if (i % 5 == 0) raddr[AW-1:0] = waddr[2*AW-1:AW];
      cycle();
    end

    // Fill with nonzero data, then reset mid-operation and re-sweep.
    for (int i = 0; i < ND / 2; i++) begin
      idle();
      wr(0, 2 * i, $urandom | 32'h1);
      wr(1, 2 * i + 1, $urandom | 32'h1);
      rd(0, i); rd(1, ND - 1 - i);
      cycle();
    end
    read_all();
    do_reset();
    for (int i = 0; i < ND; i++) begin
      randomize_inputs();
      cycle();
    end
    read_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
